multicycle_control: RTL and testbench

- Moore control FSM for the multicycle MIPS datapath.
- Consumes op/funct/zero from the datapath; drives every datapath select and write enable.
- One instruction executes per 3-5 clk cycles; the FSM returns to FETCH after each instruction.

---
 rtl/multicycle_pkg.sv | 107 ++++++++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control_alu_decoder.sv | 32 +++
 rtl/multicycle_control.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encodings,
// opcode/funct constants, ALU operation codes and datapath mux select codes.
// Optional feature macro: MULTICYCLE_GPIO_IN_EN (adds the gpin opcode and GPINEX state).
package multicycle_pkg;

  localparam int MC_STATE_W = 4;

  // FSM states; encoding 15 is only used when the gpin extension is built.
  typedef enum logic [MC_STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IWB     = 4'd11,
    S_JUMP    = 4'd12,
    S_JAL     = 4'd13,
    S_JR      = 4'd14
`ifdef MULTICYCLE_GPIO_IN_EN
    ,
    S_GPINEX  = 4'd15
`endif
  } state_t;

  // Opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_GPIN  = 6'h3F;

  // R-type funct codes (Instr[5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALUControl codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp codes passed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // Datapath mux select codes
  localparam logic       IORD_PC       = 1'b0;
  localparam logic       IORD_ALUOUT   = 1'b1;
  localparam logic       SRCA_PC       = 1'b0;
  localparam logic       SRCA_REG      = 1'b1;
  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2  = 2'b11;
  localparam logic [1:0] PCSRC_RESULT  = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;
  localparam logic [1:0] PCSRC_REG     = 2'b11;
  localparam logic [1:0] REGDST_RT     = 2'b00;
  localparam logic [1:0] REGDST_RD     = 2'b01;
  localparam logic [1:0] REGDST_RA     = 2'b10;
  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM  = 2'b01;
  localparam logic [1:0] MEMTOREG_PC   = 2'b10;

  // Bundle of every control output driven towards the datapath
  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       ori;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctrl_t;

  // True for an R-type funct that the execute stage can perform
  function automatic logic funct_is_alu(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath bus for the multicycle MIPS: decode fields and zero flag
// flow from the datapath, selects and enables flow back to it.
// Optional feature macro: MULTICYCLE_GPIO_IN_EN (Ori only toggles when defined).
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               PCen;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSrc;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic               Ori;
  logic [2:0]         ALUControl;
  logic               illegal_o;
  logic [STATE_W-1:0] state_o;

  // Controller side
  modport master (
    input  op, funct, zero,
    output PCen, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB, PCSrc,
           RegDst, MemtoReg, Ori, ALUControl, illegal_o, state_o
  );

  // Datapath side
  modport slave (
    output op, funct, zero,
    input  PCen, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB, PCSrc,
           RegDst, MemtoReg, Ori, ALUControl, illegal_o, state_o
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp and the instruction funct field to the
// 3-bit ALUControl code. Purely combinational.
// Optional feature macro: MULTICYCLE_GPIO_IN_EN (no effect in this file).
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Select the ALU operation; unknown functs fall back to AND (harmless, never written back)
  always_comb begin
    alucontrol = ALU_AND;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_OR:  alucontrol = ALU_OR;
      default: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath. Outputs decode from the
// state register (PCen in BRANCH also looks at zero); reset gates every output.
// Optional feature macro: MULTICYCLE_GPIO_IN_EN (gpin opcode 0x3F -> GPINEX).
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int STATE_W = MC_STATE_W
)(
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_t            state_reg;
  state_t            state_next;
  logic              illegal_next;
  ctrl_t             ctrl_dec;
  ctrl_t             ctrl_out;
  logic              alu_en;
  logic [1:0]        aluop;
  logic [2:0]        alu_ctl;
  logic [STATE_W-1:0] state_dbg;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; DECODE flags unknown op/funct and returns to FETCH
  always_comb begin
    state_next   = S_FETCH;
    illegal_next = 1'b0;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:   state_next = S_MEMADR;
          OP_RTYPE: begin
            if (bus.funct == FN_JR) begin
              state_next = S_JR;
            end else if (funct_is_alu(bus.funct)) begin
              state_next = S_RTYPEEX;
            end else begin
              illegal_next = 1'b1;
            end
          end
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_ADDI:        state_next = S_ADDIEX;
          OP_ORI:         state_next = S_ORIEX;
          OP_J:           state_next = S_JUMP;
          OP_JAL:         state_next = S_JAL;
`ifdef MULTICYCLE_GPIO_IN_EN
          OP_GPIN:        state_next = S_GPINEX;
`endif
          default:        illegal_next = 1'b1;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LW) begin
          state_next = S_MEMRD;
        end else if (bus.op == OP_SW) begin
          state_next = S_MEMWR;
        end
      end
      S_MEMRD:   state_next = S_MEMWB;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_ADDIEX:  state_next = S_IWB;
      S_ORIEX:   state_next = S_IWB;
`ifdef MULTICYCLE_GPIO_IN_EN
      S_GPINEX:  state_next = S_IWB;
`endif
      default:   state_next = S_FETCH;
    endcase
  end

  // Per-state output decode; anything not set here stays 0
  always_comb begin
    ctrl_dec = '0;
    alu_en   = 1'b0;
    aluop    = ALUOP_ADD;
    case (state_reg)
      S_FETCH: begin
        ctrl_dec.iord    = IORD_PC;
        ctrl_dec.irwrite = 1'b1;
        ctrl_dec.alusrca = SRCA_PC;
        ctrl_dec.alusrcb = SRCB_FOUR;
        ctrl_dec.pcsrc   = PCSRC_RESULT;
        ctrl_dec.pcen    = 1'b1;
        alu_en           = 1'b1;
        aluop            = ALUOP_ADD;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALU_o
        ctrl_dec.alusrca = SRCA_PC;
        ctrl_dec.alusrcb = SRCB_IMM_SH2;
        alu_en           = 1'b1;
        aluop            = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_dec.alusrca = SRCA_REG;
        ctrl_dec.alusrcb = SRCB_IMM;
        alu_en           = 1'b1;
        aluop            = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_dec.iord = IORD_ALUOUT;
      end
      S_MEMWB: begin
        ctrl_dec.regdst   = REGDST_RT;
        ctrl_dec.memtoreg = MEMTOREG_MEM;
        ctrl_dec.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_dec.iord     = IORD_ALUOUT;
        ctrl_dec.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl_dec.alusrca = SRCA_REG;
        ctrl_dec.alusrcb = SRCB_REG;
        alu_en           = 1'b1;
        aluop            = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl_dec.regdst   = REGDST_RD;
        ctrl_dec.memtoreg = MEMTOREG_ALU;
        ctrl_dec.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_dec.alusrca = SRCA_REG;
        ctrl_dec.alusrcb = SRCB_REG;
        ctrl_dec.pcsrc   = PCSRC_ALUOUT;
        ctrl_dec.pcen    = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
        alu_en           = 1'b1;
        aluop            = ALUOP_SUB;
      end
      S_ORIEX: begin
        // Immediate arrives sign-extended; the datapath has no zero-extend path
        ctrl_dec.alusrca = SRCA_REG;
        ctrl_dec.alusrcb = SRCB_IMM;
        alu_en           = 1'b1;
        aluop            = ALUOP_OR;
      end
`ifdef MULTICYCLE_GPIO_IN_EN
      S_GPINEX: begin
        ctrl_dec.ori     = 1'b1;
        ctrl_dec.alusrca = SRCA_REG;
        ctrl_dec.alusrcb = SRCB_IMM;
        alu_en           = 1'b1;
        aluop            = ALUOP_OR;
      end
`endif
      S_IWB: begin
        ctrl_dec.regdst   = REGDST_RT;
        ctrl_dec.memtoreg = MEMTOREG_ALU;
        ctrl_dec.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl_dec.pcsrc = PCSRC_JUMP;
        ctrl_dec.pcen  = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4, so it is the link value
        ctrl_dec.pcsrc    = PCSRC_JUMP;
        ctrl_dec.pcen     = 1'b1;
        ctrl_dec.regdst   = REGDST_RA;
        ctrl_dec.memtoreg = MEMTOREG_PC;
        ctrl_dec.regwrite = 1'b1;
      end
      S_JR: begin
        ctrl_dec.pcsrc = PCSRC_REG;
        ctrl_dec.pcen  = 1'b1;
      end
      default: ctrl_dec = '0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (alu_ctl)
  );

  // Merge ALU code and illegal flag, then force everything quiet during reset
  always_comb begin
    ctrl_out            = ctrl_dec;
    ctrl_out.alucontrol = alu_en ? alu_ctl : 3'b000;
    ctrl_out.illegal    = illegal_next;
    if (reset) begin
      ctrl_out = '0;
    end
  end

  assign state_dbg = STATE_W'(state_reg);

  assign bus.PCen       = ctrl_out.pcen;
  assign bus.IorD       = ctrl_out.iord;
  assign bus.MemWrite   = ctrl_out.memwrite;
  assign bus.IRWrite    = ctrl_out.irwrite;
  assign bus.RegWrite   = ctrl_out.regwrite;
  assign bus.ALUSrcA    = ctrl_out.alusrca;
  assign bus.ALUSrcB    = ctrl_out.alusrcb;
  assign bus.PCSrc      = ctrl_out.pcsrc;
  assign bus.RegDst     = ctrl_out.regdst;
  assign bus.MemtoReg   = ctrl_out.memtoreg;
  assign bus.Ori        = ctrl_out.ori;
  assign bus.ALUControl = ctrl_out.alucontrol;
  assign bus.illegal_o  = ctrl_out.illegal;
  assign bus.state_o    = state_dbg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: each step drives one cycle of
// inputs and queues the expected outputs; a negedge checker pops and compares.
// Optional feature macro: MULTICYCLE_GPIO_IN_EN (changes expectations for op 0x3F).
module tb_multicycle_control;
  import multicycle_pkg::*;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       ori;
    logic [2:0] aluctl;
    logic       illegal;
    logic [3:0] state;
  } obs_t;

  logic clk;
  logic reset;
  multicycle_control_if #(.STATE_W(4)) bus ();

  multicycle_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];
  string tag_q[$];
  obs_t obs;

  always_comb begin
    obs = '{pcen: bus.PCen, iord: bus.IorD, memwrite: bus.MemWrite,
            irwrite: bus.IRWrite, regwrite: bus.RegWrite, alusrca: bus.ALUSrcA,
            alusrcb: bus.ALUSrcB, pcsrc: bus.PCSrc, regdst: bus.RegDst,
            memtoreg: bus.MemtoReg, ori: bus.Ori, aluctl: bus.ALUControl,
            illegal: bus.illegal_o, state: bus.state_o};
  end

  // Expected outputs for a state, written straight from the state table
  function automatic obs_t want(input state_t st, input logic br_pcen,
                                input logic [2:0] rt_alu, input logic ill);
    obs_t e;
    e = '0;
    e.state = st;
    case (st)
      S_FETCH:   begin e.irwrite = 1; e.alusrcb = 2'b01; e.aluctl = 3'b010; e.pcen = 1; end
      S_DECODE:  begin e.alusrcb = 2'b11; e.aluctl = 3'b010; e.illegal = ill; end
      S_MEMADR:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluctl = 3'b010; end
      S_MEMRD:   begin e.iord = 1; end
      S_MEMWB:   begin e.memtoreg = 2'b01; e.regwrite = 1; end
      S_MEMWR:   begin e.iord = 1; e.memwrite = 1; end
      S_RTYPEEX: begin e.alusrca = 1; e.alusrcb = 2'b00; e.aluctl = rt_alu; end
      S_RTYPEWB: begin e.regdst = 2'b01; e.regwrite = 1; end
      S_BRANCH:  begin e.alusrca = 1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcen = br_pcen; end
      S_ADDIEX:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluctl = 3'b010; end
      S_ORIEX:   begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluctl = 3'b001; end
      S_IWB:     begin e.regwrite = 1; end
      S_JUMP:    begin e.pcsrc = 2'b10; e.pcen = 1; end
      S_JAL:     begin e.pcsrc = 2'b10; e.pcen = 1; e.regdst = 2'b10; e.memtoreg = 2'b10; e.regwrite = 1; end
      S_JR:      begin e.pcsrc = 2'b11; e.pcen = 1; end
`ifdef MULTICYCLE_GPIO_IN_EN
      S_GPINEX:  begin e.ori = 1; e.alusrca = 1; e.alusrcb = 2'b10; e.aluctl = 3'b001; end
`endif
      default:   e = '0;
    endcase
    return e;
  endfunction

  function automatic obs_t ws(input state_t st);
    return want(st, 1'b0, 3'b000, 1'b0);
  endfunction

  // Everything quiet while reset is high; only the debug state is visible
  function automatic obs_t wrst(input state_t st);
    obs_t e;
    e = '0;
    e.state = st;
    return e;
  endfunction

  task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input obs_t e, input string tag);
    reset     = rst;
    bus.op    = o;
    bus.funct = f;
    bus.zero  = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard checker: compare mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
      $display("check %s state=%0d obs=%h", t, obs.state, obs);
    end
  end

  initial begin
    reset     = 1'b1;
    bus.op    = 6'h00;
    bus.funct = 6'h00;
    bus.zero  = 1'b0;
    @(posedge clk);
    #1;

    // Reset held three cycles
    step(1, 6'h00, 6'h00, 0, wrst(S_FETCH), "reset1");
    step(1, 6'h00, 6'h00, 0, wrst(S_FETCH), "reset2");
    step(1, 6'h00, 6'h00, 0, wrst(S_FETCH), "reset3");

    // lw: 5 cycles
    step(0, 6'h23, 6'h00, 0, ws(S_FETCH),  "lw_fetch");
    step(0, 6'h23, 6'h00, 0, ws(S_DECODE), "lw_decode");
    step(0, 6'h23, 6'h00, 0, ws(S_MEMADR), "lw_memadr");
    step(0, 6'h23, 6'h00, 0, ws(S_MEMRD),  "lw_memrd");
    step(0, 6'h23, 6'h00, 0, ws(S_MEMWB),  "lw_memwb");

    // R-type sub, and, slt
    step(0, 6'h00, 6'h22, 0, ws(S_FETCH),  "sub_fetch");
    step(0, 6'h00, 6'h22, 0, ws(S_DECODE), "sub_decode");
    step(0, 6'h00, 6'h22, 0, want(S_RTYPEEX, 0, 3'b110, 0), "sub_ex");
    step(0, 6'h00, 6'h22, 0, ws(S_RTYPEWB), "sub_wb");
    step(0, 6'h00, 6'h24, 0, ws(S_FETCH),  "and_fetch");
    step(0, 6'h00, 6'h24, 0, ws(S_DECODE), "and_decode");
    step(0, 6'h00, 6'h24, 0, want(S_RTYPEEX, 0, 3'b000, 0), "and_ex");
    step(0, 6'h00, 6'h24, 0, ws(S_RTYPEWB), "and_wb");
    step(0, 6'h00, 6'h2A, 0, ws(S_FETCH),  "slt_fetch");
    step(0, 6'h00, 6'h2A, 0, ws(S_DECODE), "slt_decode");
    step(0, 6'h00, 6'h2A, 0, want(S_RTYPEEX, 0, 3'b111, 0), "slt_ex");
    step(0, 6'h00, 6'h2A, 0, ws(S_RTYPEWB), "slt_wb");

    // beq taken / not taken, bne taken / not taken
    step(0, 6'h04, 6'h00, 1, ws(S_FETCH),  "beq1_fetch");
    step(0, 6'h04, 6'h00, 1, ws(S_DECODE), "beq1_decode");
    step(0, 6'h04, 6'h00, 1, want(S_BRANCH, 1, 3'b000, 0), "beq_z1");
    step(0, 6'h04, 6'h00, 0, ws(S_FETCH),  "beq0_fetch");
    step(0, 6'h04, 6'h00, 0, ws(S_DECODE), "beq0_decode");
    step(0, 6'h04, 6'h00, 0, want(S_BRANCH, 0, 3'b000, 0), "beq_z0");
    step(0, 6'h05, 6'h00, 0, ws(S_FETCH),  "bne0_fetch");
    step(0, 6'h05, 6'h00, 0, ws(S_DECODE), "bne0_decode");
    step(0, 6'h05, 6'h00, 0, want(S_BRANCH, 1, 3'b000, 0), "bne_z0");
    step(0, 6'h05, 6'h00, 1, ws(S_FETCH),  "bne1_fetch");
    step(0, 6'h05, 6'h00, 1, ws(S_DECODE), "bne1_decode");
    step(0, 6'h05, 6'h00, 1, want(S_BRANCH, 0, 3'b000, 0), "bne_z1");

    // jal, j, jr
    step(0, 6'h03, 6'h00, 0, ws(S_FETCH),  "jal_fetch");
    step(0, 6'h03, 6'h00, 0, ws(S_DECODE), "jal_decode");
    step(0, 6'h03, 6'h00, 0, ws(S_JAL),    "jal_jal");
    step(0, 6'h02, 6'h00, 0, ws(S_FETCH),  "j_fetch");
    step(0, 6'h02, 6'h00, 0, ws(S_DECODE), "j_decode");
    step(0, 6'h02, 6'h00, 0, ws(S_JUMP),   "j_jump");
    step(0, 6'h00, 6'h08, 0, ws(S_FETCH),  "jr_fetch");
    step(0, 6'h00, 6'h08, 0, ws(S_DECODE), "jr_decode");
    step(0, 6'h00, 6'h08, 0, ws(S_JR),     "jr_jr");

    // addi, ori
    step(0, 6'h08, 6'h00, 0, ws(S_FETCH),  "addi_fetch");
    step(0, 6'h08, 6'h00, 0, ws(S_DECODE), "addi_decode");
    step(0, 6'h08, 6'h00, 0, ws(S_ADDIEX), "addi_ex");
    step(0, 6'h08, 6'h00, 0, ws(S_IWB),    "addi_wb");
    step(0, 6'h0D, 6'h00, 0, ws(S_FETCH),  "ori_fetch");
    step(0, 6'h0D, 6'h00, 0, ws(S_DECODE), "ori_decode");
    step(0, 6'h0D, 6'h00, 0, ws(S_ORIEX),  "ori_ex");
    step(0, 6'h0D, 6'h00, 0, ws(S_IWB),    "ori_wb");

    // op 0x3F: illegal unless the gpin extension is built
    step(0, 6'h3F, 6'h00, 0, ws(S_FETCH),  "gpin_fetch");
`ifdef MULTICYCLE_GPIO_IN_EN
    step(0, 6'h3F, 6'h00, 0, ws(S_DECODE), "gpin_decode");
    step(0, 6'h3F, 6'h00, 0, ws(S_GPINEX), "gpin_ex");
    step(0, 6'h3F, 6'h00, 0, ws(S_IWB),    "gpin_wb");
`else
    step(0, 6'h3F, 6'h00, 0, want(S_DECODE, 0, 3'b000, 1), "gpin_illegal");
`endif

    // Unknown R-type funct is illegal too, then straight back to FETCH
    step(0, 6'h00, 6'h3F, 0, ws(S_FETCH),  "badfn_fetch");
    step(0, 6'h00, 6'h3F, 0, want(S_DECODE, 0, 3'b000, 1), "badfn_illegal");
    step(0, 6'h00, 6'h3F, 0, ws(S_FETCH),  "badfn_refetch");

    // sw aborted by reset in MEMWR: no write that cycle, FETCH follows
    step(0, 6'h2B, 6'h00, 0, ws(S_DECODE), "sw_decode");
    step(0, 6'h2B, 6'h00, 0, ws(S_MEMADR), "sw_memadr");
    step(1, 6'h2B, 6'h00, 0, wrst(S_MEMWR), "sw_reset_memwr");
    step(0, 6'h2B, 6'h00, 0, ws(S_FETCH),  "after_reset_fetch");

    // Full sw without abort
    step(0, 6'h2B, 6'h00, 0, ws(S_DECODE), "sw2_decode");
    step(0, 6'h2B, 6'h00, 0, ws(S_MEMADR), "sw2_memadr");
    step(0, 6'h2B, 6'h00, 0, ws(S_MEMWR),  "sw2_memwr");
    step(0, 6'h00, 6'h20, 0, ws(S_FETCH),  "final_fetch");

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain observed=%0d pending expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
